tm1638_responder: RTL and testbench

- SPI responder that emulates the TM1638 end of the 3-wire STB/CLK/DIO link, for FPGA loopback tests and bench self-checks of the command-issuing SPI master.
- Oversamples the serial lines, decodes TM1638 commands LSB-first and keeps a 16x8 display RAM and a display-control register.
- Returns 4 key-scan bytes on a read command.
- The tristate on DIO is split into in/out/output-enable; the top level builds the pad.

---
 rtl/tm1638_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_tm1638_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_responder.sv
// TM1638-style responder: decodes LSB-first commands on a STB/CLK/DIO link,
// keeps a 16x8 display RAM plus a display-control register, and shifts out
// four key-scan bytes on a read command. DIO is split into in/out/oe.
//
// state   | meaning
// IDLE    | frame closed, waiting for STB falling edge
// CMD     | shifting in the command byte
// WDATA   | shifting data bytes into RAM[pointer]
// RDATA   | shifting out the 32 latched key bits
// IGNORE  | discarding bits until STB rises
module tm1638_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_SPI_Stb,
  input  logic        i_SPI_Clk,
  input  logic        i_SPI_Dio,
  output logic        o_SPI_Dio,
  output logic        o_SPI_Dio_Oe,
  input  logic [31:0] i_Keys,
  input  logic [3:0]  i_Ram_Rd_Addr,
  output logic [7:0]  o_Ram_Rd_Data,
  output logic [3:0]  o_Display_Ctrl,
  output logic        o_Cmd_Valid,
  output logic [7:0]  o_Cmd,
  output logic        o_Cmd_Err,
  output logic        o_Wr_Valid,
  output logic [3:0]  o_Wr_Addr,
  output logic [7:0]  o_Wr_Data
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_WDATA  = 3'd2,
    ST_RDATA  = 3'd3,
    ST_IGNORE = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] r_stb_sync;
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dio_sync;
  logic                   r_stb_prev;
  logic                   r_clk_prev;

  logic       w_stb;
  logic       w_clk;
  logic       w_dio;
  logic       w_clk_rise;
  logic       w_clk_fall;
  logic       w_stb_fall;
  logic       w_byte_done;
  logic [7:0] w_byte;

  state_t      r_state;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [31:0] r_rd_shift;
  logic [5:0]  r_rd_cnt;
  logic [3:0]  r_ptr;
  logic        r_fixed;
  logic [7:0]  r_ram [16];

  logic        r_dio_out;
  logic        r_dio_oe;
  logic [3:0]  r_disp_ctrl;
  logic        r_cmd_valid;
  logic [7:0]  r_cmd;
  logic        r_cmd_err;
  logic        r_wr_valid;
  logic [3:0]  r_wr_addr;
  logic [7:0]  r_wr_data;

  assign w_stb       = r_stb_sync[SYNC_STAGES-1];
  assign w_clk       = r_clk_sync[SYNC_STAGES-1];
  assign w_dio       = r_dio_sync[SYNC_STAGES-1];
  assign w_clk_rise  = w_clk & ~r_clk_prev;
  assign w_clk_fall  = ~w_clk & r_clk_prev;
  assign w_stb_fall  = ~w_stb & r_stb_prev;
  // Bits arrive LSB first and enter at the top of r_shift.
  assign w_byte      = {w_dio, r_shift[7:1]};
  assign w_byte_done = w_clk_rise && (r_bit_cnt == 3'd7);

  // Synchronise the serial lines and keep one delayed copy for edge detection.
  // Reset to 0 so a STB held low through reset cannot look like a new frame.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_stb_sync <= '0;
      r_clk_sync <= '0;
      r_dio_sync <= '0;
      r_stb_prev <= 1'b0;
      r_clk_prev <= 1'b0;
    end else begin
      r_stb_sync <= {r_stb_sync[SYNC_STAGES-2:0], i_SPI_Stb};
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_SPI_Clk};
      r_dio_sync <= {r_dio_sync[SYNC_STAGES-2:0], i_SPI_Dio};
      r_stb_prev <= w_stb;
      r_clk_prev <= w_clk;
    end
  end

  // Frame FSM: command decode, RAM writes, key readout and registered outputs.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rd_shift  <= '0;
      r_rd_cnt    <= '0;
      r_ptr       <= '0;
      r_fixed     <= 1'b0;
      r_dio_out   <= 1'b0;
      r_dio_oe    <= 1'b0;
      r_disp_ctrl <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd       <= '0;
      r_cmd_err   <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      for (int i = 0; i < 16; i++) r_ram[i] <= '0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_wr_valid  <= 1'b0;
      if (r_state != ST_IDLE && w_stb) begin
        // Frame closed: any partial byte is simply dropped.
        r_state   <= ST_IDLE;
        r_dio_oe  <= 1'b0;
        r_dio_out <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_stb_fall) begin
              r_bit_cnt <= '0;
              r_state   <= ST_CMD;
            end
          end
          ST_CMD: begin
            if (w_clk_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_byte_done) begin
              r_cmd       <= w_byte;
              r_cmd_valid <= 1'b1;
              case (w_byte[7:6])
                2'b01: begin
                  if (w_byte[1]) begin
                    r_rd_shift <= i_Keys;
                    r_rd_cnt   <= '0;
                    r_state    <= ST_RDATA;
                  end else begin
                    r_fixed <= w_byte[2];
                    r_state <= ST_IGNORE;
                  end
                end
                2'b10: begin
                  r_disp_ctrl <= w_byte[3:0];
                  r_state     <= ST_IGNORE;
                end
                2'b11: begin
                  r_ptr   <= w_byte[3:0];
                  r_state <= ST_WDATA;
                end
                default: begin
                  r_cmd_err <= 1'b1;
                  r_state   <= ST_IGNORE;
                end
              endcase
            end
          end
          ST_WDATA: begin
            if (w_clk_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_byte_done) begin
              r_ram[r_ptr] <= w_byte;
              r_wr_valid   <= 1'b1;
              r_wr_addr    <= r_ptr;
              r_wr_data    <= w_byte;
              if (!r_fixed) r_ptr <= r_ptr + 4'd1;
            end
          end
          ST_RDATA: begin
            // Falling edges present bits; rising edges count master samples.
            if (w_clk_fall) begin
              if (r_rd_cnt == 6'd32) begin
                r_dio_oe  <= 1'b0;
                r_dio_out <= 1'b0;
                r_state   <= ST_IGNORE;
              end else begin
                r_dio_oe   <= 1'b1;
                r_dio_out  <= r_rd_shift[0];
                r_rd_shift <= {1'b0, r_rd_shift[31:1]};
              end
            end
            if (w_clk_rise && r_rd_cnt != 6'd32) r_rd_cnt <= r_rd_cnt + 6'd1;
          end
          ST_IGNORE: begin
            r_dio_oe <= 1'b0;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_Ram_Rd_Data  = r_ram[i_Ram_Rd_Addr];
  assign o_SPI_Dio      = r_dio_out;
  assign o_SPI_Dio_Oe   = r_dio_oe;
  assign o_Display_Ctrl = r_disp_ctrl;
  assign o_Cmd_Valid    = r_cmd_valid;
  assign o_Cmd          = r_cmd;
  assign o_Cmd_Err      = r_cmd_err;
  assign o_Wr_Valid     = r_wr_valid;
  assign o_Wr_Addr      = r_wr_addr;
  assign o_Wr_Data      = r_wr_data;

endmodule

// File: tb/tb_tm1638_responder.sv
// Bench for tm1638_responder: drives TM1638 master frames and checks pulses,
// RAM contents, display control and key readout against a frame-level model.
module tb_tm1638_responder;

  localparam int HALF = 8;

  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b0;
  logic        i_SPI_Stb = 1'b1;
  logic        i_SPI_Clk = 1'b1;
  logic        i_SPI_Dio = 1'b0;
  logic [31:0] i_Keys = '0;
  logic [3:0]  i_Ram_Rd_Addr = '0;
  logic        o_SPI_Dio, o_SPI_Dio_Oe, o_Cmd_Valid, o_Cmd_Err, o_Wr_Valid;
  logic [7:0]  o_Ram_Rd_Data, o_Cmd, o_Wr_Data;
  logic [3:0]  o_Display_Ctrl, o_Wr_Addr;

  tm1638_responder #(.SYNC_STAGES(2)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst),
    .i_SPI_Stb(i_SPI_Stb), .i_SPI_Clk(i_SPI_Clk), .i_SPI_Dio(i_SPI_Dio),
    .o_SPI_Dio(o_SPI_Dio), .o_SPI_Dio_Oe(o_SPI_Dio_Oe),
    .i_Keys(i_Keys), .i_Ram_Rd_Addr(i_Ram_Rd_Addr), .o_Ram_Rd_Data(o_Ram_Rd_Data),
    .o_Display_Ctrl(o_Display_Ctrl), .o_Cmd_Valid(o_Cmd_Valid), .o_Cmd(o_Cmd),
    .o_Cmd_Err(o_Cmd_Err), .o_Wr_Valid(o_Wr_Valid), .o_Wr_Addr(o_Wr_Addr),
    .o_Wr_Data(o_Wr_Data)
  );

  always #5 i_Clk = ~i_Clk;

  int checks = 0;
  int errors = 0;

  // Frame-level model state
  logic [7:0]  m_ram [16];
  logic [3:0]  m_ctrl;
  logic [3:0]  m_ptr;
  logic        m_fixed;
  int          m_err_cnt;
  int          seen_err;
  logic [7:0]  exp_cmd_q [$];
  logic [11:0] exp_wr_q [$];
  logic [7:0]  fq [$];
  logic [31:0] rd_word;
  logic [7:0]  rd_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=pulse required=none", name);
  endtask

  // Per-cycle pulse checker
  always @(negedge i_Clk) begin
    if (i_Rst) begin
      if (o_Cmd_Valid) begin
        if (exp_cmd_q.size() == 0) unexpected("cmd_valid");
        else check("cmd", {24'd0, o_Cmd}, {24'd0, exp_cmd_q.pop_front()});
      end
      if (o_Wr_Valid) begin
        if (exp_wr_q.size() == 0) unexpected("wr_valid");
        else check("wr_addr_data", {20'd0, o_Wr_Addr, o_Wr_Data}, {20'd0, exp_wr_q.pop_front()});
        if (o_Cmd_Valid || o_Cmd_Err) unexpected("pulse_overlap");
      end
      if (o_Cmd_Err) seen_err++;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
    m_ctrl = 4'h0; m_ptr = 4'h0; m_fixed = 1'b0;
    m_err_cnt = 0; seen_err = 0;
    exp_cmd_q.delete(); exp_wr_q.delete();
  endtask

  // Applies the complete bytes in fq to the model.
  task automatic model_frame();
    logic [7:0] c;
    c = fq[0];
    exp_cmd_q.push_back(c);
    case (c[7:6])
      2'b00: m_err_cnt++;
      2'b01: if (!c[1]) m_fixed = c[2];
      2'b10: m_ctrl = c[3:0];
      default: begin
        m_ptr = c[3:0];
        for (int i = 1; i < fq.size(); i++) begin
          exp_wr_q.push_back({m_ptr, fq[i]});
          m_ram[m_ptr] = fq[i];
          if (!m_fixed) m_ptr = m_ptr + 4'd1;
        end
      end
    endcase
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      i_SPI_Clk = 1'b0;
      i_SPI_Dio = b[i];
      wait_cyc(HALF);
      i_SPI_Clk = 1'b1;
      wait_cyc(HALF);
    end
  endtask

  task automatic run_frame(input int partial_bits);
    model_frame();
    i_SPI_Stb = 1'b0;
    wait_cyc(HALF);
    for (int i = 0; i < fq.size(); i++) spi_bits(fq[i], 8);
    if (partial_bits > 0) spi_bits(8'hFF, partial_bits);
    wait_cyc(HALF);
    i_SPI_Stb = 1'b1;
    wait_cyc(6 * HALF);
  endtask

  task automatic rd_ram(input logic [3:0] a, output logic [7:0] d);
    i_Ram_Rd_Addr = a;
    #1;
    d = o_Ram_Rd_Data;
  endtask

  task automatic check_state(input string tag);
    logic [7:0] d;
    for (int a = 0; a < 16; a++) begin
      rd_ram(a[3:0], d);
      check($sformatf("%s_ram[%0d]", tag, a), {24'd0, d}, {24'd0, m_ram[a]});
    end
    check({tag, "_ctrl"}, {28'd0, o_Display_Ctrl}, {28'd0, m_ctrl});
    check({tag, "_wr_pending"}, exp_wr_q.size(), 0);
    check({tag, "_cmd_pending"}, exp_cmd_q.size(), 0);
    check({tag, "_err_count"}, seen_err, m_err_cnt);
  endtask

  task automatic read_frame(output logic [31:0] word);
    fq = '{8'h42};
    model_frame();
    word = '0;
    i_SPI_Stb = 1'b0;
    wait_cyc(HALF);
    spi_bits(8'h42, 8);
    for (int i = 0; i < 32; i++) begin
      i_SPI_Clk = 1'b0;
      wait_cyc(HALF);
      check($sformatf("oe_bit%0d", i), {31'd0, o_SPI_Dio_Oe}, 32'd1);
      i_SPI_Clk = 1'b1;
      word[i] = o_SPI_Dio;
      wait_cyc(HALF);
    end
    i_SPI_Clk = 1'b0;
    wait_cyc(HALF);
    check("oe_after_32", {31'd0, o_SPI_Dio_Oe}, 32'd0);
    i_SPI_Clk = 1'b1;
    wait_cyc(HALF);
    i_SPI_Stb = 1'b1;
    wait_cyc(6 * HALF);
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [7:0] d;
    check({tag, "_dio"}, {31'd0, o_SPI_Dio}, 32'd0);
    check({tag, "_oe"}, {31'd0, o_SPI_Dio_Oe}, 32'd0);
    check({tag, "_ctrl"}, {28'd0, o_Display_Ctrl}, 32'd0);
    check({tag, "_cmd"}, {24'd0, o_Cmd}, 32'd0);
    check({tag, "_pulses"}, {29'd0, o_Cmd_Valid, o_Cmd_Err, o_Wr_Valid}, 32'd0);
    check({tag, "_wr"}, {20'd0, o_Wr_Addr, o_Wr_Data}, 32'd0);
    for (int a = 0; a < 16; a++) begin
      rd_ram(a[3:0], d);
      check($sformatf("%s_ram[%0d]", tag, a), {24'd0, d}, 32'd0);
    end
  endtask

  initial begin
    model_reset();
    wait_cyc(4);
    check_reset_outputs("por");
    i_Rst = 1'b1;
    wait_cyc(4);

    // Auto-increment writes at 0,1,2
    fq = '{8'h40}; run_frame(0);
    fq = '{8'hC0, 8'h11, 8'h22, 8'h33}; run_frame(0);
    check_state("auto");
    rd_ram(4'd0, rd_val); check("lit_ram0", {24'd0, rd_val}, 32'h11);
    rd_ram(4'd2, rd_val); check("lit_ram2", {24'd0, rd_val}, 32'h33);
    check("lit_no_err", seen_err, 0);

    // Fixed address
    fq = '{8'h44}; run_frame(0);
    fq = '{8'hC5, 8'hAA, 8'hBB}; run_frame(0);
    check_state("fixed");
    rd_ram(4'd5, rd_val); check("lit_ram5", {24'd0, rd_val}, 32'hBB);
    rd_ram(4'd6, rd_val); check("lit_ram6", {24'd0, rd_val}, 32'h00);

    // Pointer wrap
    fq = '{8'h40}; run_frame(0);
    fq = '{8'hCF, 8'h01, 8'h02}; run_frame(0);
    check_state("wrap");
    rd_ram(4'd15, rd_val); check("lit_ram15", {24'd0, rd_val}, 32'h01);
    rd_ram(4'd0, rd_val);  check("lit_ram0_wrap", {24'd0, rd_val}, 32'h02);

    // Display control
    fq = '{8'h8B}; run_frame(0);
    check("lit_ctrl_b", {28'd0, o_Display_Ctrl}, 32'hB);
    fq = '{8'h87}; run_frame(0);
    check("lit_ctrl_7", {28'd0, o_Display_Ctrl}, 32'h7);
    check_state("disp");

    // Key readout
    i_Keys = 32'h04030201;
    read_frame(rd_word);
    check("read_model", rd_word, i_Keys);
    check("lit_read", rd_word, 32'h04030201);
    i_Keys = 32'hA5C3_0FF0;
    read_frame(rd_word);
    check("read_model2", rd_word, i_Keys);
    check_state("read");

    // Partial byte dropped, then illegal command
    fq = '{8'hC8, 8'h77}; run_frame(5);
    check_state("partial");
    fq = '{8'h15}; run_frame(0);
    check_state("err");
    check("lit_err_one", seen_err, 1);

    // Reset in the middle of a write frame
    fq = '{8'h44}; run_frame(0);
    exp_cmd_q.push_back(8'hC2);
    i_SPI_Stb = 1'b0;
    wait_cyc(HALF);
    spi_bits(8'hC2, 8);
    spi_bits(8'h5A, 3);
    i_Rst = 1'b0;
    wait_cyc(2);
    check_reset_outputs("midrst");
    model_reset();
    i_SPI_Stb = 1'b1;
    i_SPI_Clk = 1'b1;
    wait_cyc(4);
    i_Rst = 1'b1;
    wait_cyc(6 * HALF);
    fq = '{8'hC3, 8'h5A, 8'h6B}; run_frame(0);
    check_state("postrst");
    rd_ram(4'd4, rd_val); check("lit_postrst_auto", {24'd0, rd_val}, 32'h6B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
